// File: rtl/l2_cache_nway_pkg.sv
// Shared types for the N-way L2 cache: LC-3b line/word types and controller states.
package l2_cache_nway_pkg;

   typedef logic [127:0] lc3b_block;
   typedef logic [15:0]  lc3b_word;

   typedef enum logic [2:0] {
      ST_CHECK,
      ST_WRITEBACK,
      ST_FILL,
      ST_FLUSH_SCAN,
      ST_FLUSH_WB
   } l2_state_t;

   localparam int LINE_OFS_W = 4;

endpackage

// File: rtl/l2_cache_nway_lru.sv
// Per-set true-LRU age counters and victim selection (invalid ways first, then oldest).
module l2_lru_ages #(
   parameter int WAYS = 4,
   parameter int SETS = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [$clog2(SETS)-1:0]   i_idx,
   input  logic [WAYS-1:0]           i_valid,
   input  logic                      i_access,
   input  logic [$clog2(WAYS)-1:0]   i_way,
   output logic [$clog2(WAYS)-1:0]   o_victim
);
   localparam int AGE_W = $clog2(WAYS);

   typedef logic [WAYS-1:0][AGE_W-1:0] set_ages_t;

   logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] r_age;
   set_ages_t                            w_next_ages;
   logic [AGE_W-1:0]                     w_acc_age;
   logic                                 w_found;

   function automatic logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_init();
      logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] ages;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++)
            ages[s][w] = AGE_W'(w);
      return ages;
   endfunction

   // Ages stay a permutation of 0..WAYS-1: the accessed way becomes 0 and only younger ways age.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_acc_age   = r_age[i_idx][i_way];
      w_next_ages = r_age[i_idx];
      for (int v = 0; v < WAYS; v++) begin
         if (AGE_W'(v) == i_way)
            w_next_ages[v] = '0;
         else if (r_age[i_idx][v] < w_acc_age)
            w_next_ages[v] = r_age[i_idx][v] + 1'b1;
      end
   end

   always_comb begin
      o_victim = '0;
      w_found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!w_found && !i_valid[w]) begin
            o_victim = AGE_W'(w);
            w_found  = 1'b1;
         end
      end
      if (!w_found) begin
         for (int w = 0; w < WAYS; w++)
            if (r_age[i_idx][w] == AGE_W'(WAYS - 1))
               o_victim = AGE_W'(w);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_age <= age_init();
      else if (i_access)
         r_age[i_idx] <= w_next_ages;
   end

endmodule

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back/write-allocate L2 cache with miss handling and whole-cache flush.
module l2_cache_nway
   import l2_cache_nway_pkg::*;
#(
   parameter int WAYS = 4,
   parameter int SETS = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [15:0]  mem_address,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp,
   input  logic         flush_req,
   output logic         flush_done
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 12 - IDX_W;
   localparam int AGE_W = $clog2(WAYS);

   l2_state_t                      r_state;
   lc3b_block                      r_data [SETS][WAYS];
   logic [TAG_W-1:0]               r_tag  [SETS][WAYS];
   logic [SETS-1:0][WAYS-1:0]      r_valid;
   logic [SETS-1:0][WAYS-1:0]      r_dirty;
   logic [AGE_W-1:0]               r_victim;
   logic [IDX_W-1:0]               r_scan_set;
   logic [AGE_W-1:0]               r_scan_way;
   logic                           r_pmem_read;
   logic                           r_pmem_write;
   logic [15:0]                    r_pmem_address;
   logic                           r_flush_done;

   logic [TAG_W-1:0]               w_tag;
   logic [IDX_W-1:0]               w_idx;
   logic                           w_req;
   logic                           w_hit;
   logic [AGE_W-1:0]               w_hit_way;
   logic                           w_resp;
   logic                           w_fill_done;
   logic                           w_lru_access;
   logic [AGE_W-1:0]               w_lru_way;
   logic [AGE_W-1:0]               w_lru_victim;
   logic                           w_scan_last;
   logic [IDX_W-1:0]               w_next_set;
   logic [AGE_W-1:0]               w_next_way;
   logic                           w_unused;

   assign w_tag    = mem_address[15:LINE_OFS_W+IDX_W];
   assign w_idx    = mem_address[LINE_OFS_W+IDX_W-1:LINE_OFS_W];
   assign w_unused = ^mem_address[LINE_OFS_W-1:0];
   assign w_req    = mem_read | mem_write;

   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = AGE_W'(w);
         end
      end
   end

   assign w_resp       = (r_state == ST_CHECK) && w_req && w_hit;
   assign w_fill_done  = (r_state == ST_FILL) && pmem_resp;
   assign w_lru_access = w_resp | w_fill_done;
   assign w_lru_way    = w_resp ? w_hit_way : r_victim;

   assign w_scan_last = (r_scan_set == IDX_W'(SETS - 1)) && (r_scan_way == AGE_W'(WAYS - 1));
   assign w_next_way  = r_scan_way + 1'b1;
   assign w_next_set  = (r_scan_way == AGE_W'(WAYS - 1)) ? r_scan_set + 1'b1 : r_scan_set;

   l2_lru_ages #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_lru (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_idx    (w_idx),
      .i_valid  (r_valid[w_idx]),
      .i_access (w_lru_access),
      .i_way    (w_lru_way),
      .o_victim (w_lru_victim)
   );

   assign mem_resp     = w_resp;
   assign mem_rdata    = r_data[w_idx][w_hit_way];
   assign pmem_read    = r_pmem_read;
   assign pmem_write   = r_pmem_write;
   assign pmem_address = r_pmem_address;
   assign pmem_wdata   = (r_state == ST_FLUSH_WB) ? r_data[r_scan_set][r_scan_way]
                                                  : r_data[w_idx][r_victim];
   assign flush_done   = r_flush_done;

   // NOTE: line and tag storage is deliberately not reset; valid bits gate every use and RAMs stay inferable.
   always_ff @(posedge clk) begin
      if (w_fill_done) begin
         r_data[w_idx][r_victim] <= pmem_rdata;
         r_tag[w_idx][r_victim]  <= w_tag;
      end else if (w_resp && mem_write) begin
         r_data[w_idx][w_hit_way] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_CHECK;
         r_valid        <= '0;
         r_dirty        <= '0;
         r_victim       <= '0;
         r_scan_set     <= '0;
         r_scan_way     <= '0;
         r_pmem_read    <= 1'b0;
         r_pmem_write   <= 1'b0;
         r_pmem_address <= '0;
         r_flush_done   <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            ST_CHECK: begin
               if (w_req) begin
                  if (w_hit) begin
                     if (mem_write)
                        r_dirty[w_idx][w_hit_way] <= 1'b1;
                  end else begin
                     r_victim <= w_lru_victim;
                     if (r_dirty[w_idx][w_lru_victim]) begin
                        r_state        <= ST_WRITEBACK;
                        r_pmem_write   <= 1'b1;
                        r_pmem_address <= {r_tag[w_idx][w_lru_victim], w_idx, 4'b0};
                     end else begin
                        r_state        <= ST_FILL;
                        r_pmem_read    <= 1'b1;
                        r_pmem_address <= {w_tag, w_idx, 4'b0};
                     end
                  end
               end else if (flush_req) begin
                  r_state    <= ST_FLUSH_SCAN;
                  r_scan_set <= '0;
                  r_scan_way <= '0;
               end
            end

            ST_WRITEBACK: begin
               if (pmem_resp) begin
                  r_dirty[w_idx][r_victim] <= 1'b0;
                  r_pmem_write             <= 1'b0;
                  r_pmem_read              <= 1'b1;
                  r_pmem_address           <= {w_tag, w_idx, 4'b0};
                  r_state                  <= ST_FILL;
               end
            end

            ST_FILL: begin
               if (pmem_resp) begin
                  r_valid[w_idx][r_victim] <= 1'b1;
                  r_dirty[w_idx][r_victim] <= 1'b0;
                  r_pmem_read              <= 1'b0;
                  r_state                  <= ST_CHECK;
               end
            end

            ST_FLUSH_SCAN: begin
               if (r_valid[r_scan_set][r_scan_way] && r_dirty[r_scan_set][r_scan_way]) begin
                  r_state        <= ST_FLUSH_WB;
                  r_pmem_write   <= 1'b1;
                  r_pmem_address <= {r_tag[r_scan_set][r_scan_way], r_scan_set, 4'b0};
               end else if (w_scan_last) begin
                  r_flush_done <= 1'b1;
                  r_state      <= ST_CHECK;
               end else begin
                  r_scan_set <= w_next_set;
                  r_scan_way <= w_next_way;
               end
            end

            ST_FLUSH_WB: begin
               if (pmem_resp) begin
                  r_dirty[r_scan_set][r_scan_way] <= 1'b0;
                  r_pmem_write                    <= 1'b0;
                  if (w_scan_last) begin
                     r_flush_done <= 1'b1;
                     r_state      <= ST_CHECK;
                  end else begin
                     r_scan_set <= w_next_set;
                     r_scan_way <= w_next_way;
                     r_state    <= ST_FLUSH_SCAN;
                  end
               end
            end

            default: r_state <= ST_CHECK;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed self-checking bench for l2_cache_nway (4 ways, 8 sets) with a fixed-latency memory model.
module tb_l2_cache_nway;
   import l2_cache_nway_pkg::*;

   localparam int LAT = 3;

   localparam logic [127:0] BLK_A   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] BLK_W   = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
   localparam logic [127:0] BLK_D1  = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
   localparam logic [127:0] BLK_D2  = 128'h5555_5555_6666_6666_7777_7777_8888_8888;
   localparam logic [127:0] BLK_W2  = 128'hCAFE_F00D_CAFE_F00D_0BAD_BEEF_0BAD_BEEF;
   localparam logic [127:0] PAT_060 = 128'h5A3A_5A3A_5A3A_5A3A_5A3A_5A3A_5A3A_5A3A;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         mem_read = 1'b0;
   logic         mem_write = 1'b0;
   logic [15:0]  mem_address = '0;
   logic [127:0] mem_wdata = '0;
   logic [127:0] mem_rdata;
   logic         mem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata = '0;
   logic         pmem_resp = 1'b0;
   logic         flush_req = 1'b0;
   logic         flush_done;

   typedef struct {
      bit           wr;
      logic [15:0]  addr;
      logic [127:0] data;
   } txn_t;

   txn_t         log_q[$];
   logic [127:0] pm [logic [15:0]];
   int           pm_cnt = 0;
   bit           both_seen = 1'b0;

   int           total = 0;
   int           bad = 0;
   logic [127:0] rd;
   int           lat;
   int           pulses;
   bit           done;
   bit           seen_wb;

   l2_cache_nway #(
      .WAYS (4),
      .SETS (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .flush_req    (flush_req),
      .flush_done   (flush_done)
   );

   always #5 clk = ~clk;

   // Physical memory: answers any request LAT cycles after it is first seen, logs each completed transfer.
   initial begin : pmem_model
      forever begin
         @(negedge clk);
         if (pmem_read && pmem_write)
            both_seen = 1'b1;
         if (!reset_n) begin
            pm_cnt    = 0;
            pmem_resp = 1'b0;
         end else if (pmem_resp) begin
            pmem_resp = 1'b0;
         end else if (pmem_read || pmem_write) begin
            pm_cnt++;
            if (pm_cnt == LAT) begin
               pm_cnt    = 0;
               pmem_resp = 1'b1;
               if (pmem_write) begin
                  pm[pmem_address] = pmem_wdata;
                  log_q.push_back('{1'b1, pmem_address, pmem_wdata});
               end else begin
                  pmem_rdata = pm.exists(pmem_address) ? pm[pmem_address]
                                                       : {8{pmem_address ^ 16'h5A5A}};
                  log_q.push_back('{1'b0, pmem_address, pmem_rdata});
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_txn(input string tag, input int idx, input bit wr,
                            input logic [15:0] addr, input logic [127:0] data, input bit chk_data);
      txn_t t;
      t = (idx < log_q.size()) ? log_q[idx] : '{1'b0, 16'hxxxx, 'x};
      check({tag, " kind"}, {127'd0, t.wr}, {127'd0, wr});
      check({tag, " addr"}, {112'd0, t.addr}, {112'd0, addr});
      if (chk_data)
         check({tag, " data"}, t.data, data);
   endtask

   task automatic do_req(input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                         input bit with_flush, output logic [127:0] rdata, output int cycles);
      @(negedge clk);
      mem_address = addr;
      mem_wdata   = wd;
      mem_write   = wr;
      mem_read    = !wr;
      if (with_flush)
         flush_req = 1'b1;
      cycles = -1;
      rdata  = 'x;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (mem_resp) begin
            rdata  = mem_rdata;
            cycles = i;
            break;
         end
         @(negedge clk);
      end
      if (cycles >= 0) begin
         @(posedge clk);
         @(negedge clk);
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic wait_flush(output int n_pulses, output bit got_done);
      n_pulses = 0;
      got_done = 1'b0;
      for (int i = 0; i < 500 && !got_done; i++) begin
         @(negedge clk);
         if (flush_done) begin
            n_pulses++;
            got_done  = 1'b1;
            flush_req = 1'b0;
         end
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (flush_done)
            n_pulses++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      pm[16'h1230] = BLK_A;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("reset mem_resp", {127'd0, mem_resp}, 128'd0);
      check("reset pmem_read", {127'd0, pmem_read}, 128'd0);
      check("reset pmem_write", {127'd0, pmem_write}, 128'd0);
      check("reset pmem_address", {112'd0, pmem_address}, 128'd0);
      check("reset flush_done", {127'd0, flush_done}, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: cold read miss fills from memory then hits
      log_q.delete();
      do_req(1'b0, 16'h1230, '0, 1'b0, rd, lat);
      check("t1 miss latency", lat, 4);
      check("t1 rdata", rd, BLK_A);
      check("t1 log size", log_q.size(), 1);
      check_txn("t1 fill", 0, 1'b0, 16'h1230, BLK_A, 1'b1);

      // 2: write hit, fill the rest of set 3, dirty eviction of the LRU way
      do_req(1'b1, 16'h1230, BLK_W, 1'b0, rd, lat);
      check("t2 write hit latency", lat, 0);
      log_q.delete();
      do_req(1'b0, 16'h1330, '0, 1'b0, rd, lat);
      check("t2 clean miss latency", lat, 4);
      do_req(1'b0, 16'h1430, '0, 1'b0, rd, lat);
      do_req(1'b0, 16'h1530, '0, 1'b0, rd, lat);
      check("t2 no writeback while filling", log_q.size(), 3);
      log_q.delete();
      do_req(1'b0, 16'h1630, '0, 1'b0, rd, lat);
      check("t2 dirty miss latency", lat, 8);
      check("t2 log size", log_q.size(), 2);
      check_txn("t2 writeback", 0, 1'b1, 16'h1230, BLK_W, 1'b1);
      check_txn("t2 fill", 1, 1'b0, 16'h1630, '0, 1'b0);

      // 3: clean lines, touch 0x1230, then 0x1330 is the LRU victim
      do_reset();
      do_req(1'b0, 16'h1230, '0, 1'b0, rd, lat);
      check("t3 written-back data returns", rd, BLK_W);
      do_req(1'b0, 16'h1330, '0, 1'b0, rd, lat);
      do_req(1'b0, 16'h1430, '0, 1'b0, rd, lat);
      do_req(1'b0, 16'h1530, '0, 1'b0, rd, lat);
      do_req(1'b0, 16'h1230, '0, 1'b0, rd, lat);
      check("t3 re-read hit", lat, 0);
      log_q.delete();
      do_req(1'b0, 16'h1630, '0, 1'b0, rd, lat);
      check("t3 log size", log_q.size(), 1);
      check_txn("t3 fill", 0, 1'b0, 16'h1630, '0, 1'b0);
      do_req(1'b0, 16'h1230, '0, 1'b0, rd, lat);
      check("t3 0x1230 still hits", lat, 0);
      do_req(1'b0, 16'h1330, '0, 1'b0, rd, lat);
      check("t3 0x1330 was evicted", lat, 4);

      // 4: flush writes back set 1 way 2 then set 5 way 0
      do_req(1'b0, 16'h0010, '0, 1'b0, rd, lat);
      do_req(1'b0, 16'h0090, '0, 1'b0, rd, lat);
      do_req(1'b1, 16'h0110, BLK_D1, 1'b0, rd, lat);
      do_req(1'b1, 16'h0050, BLK_D2, 1'b0, rd, lat);
      log_q.delete();
      @(negedge clk);
      flush_req = 1'b1;
      wait_flush(pulses, done);
      check("t4 flush completes", {127'd0, done}, {127'd0, 1'b1});
      check("t4 flush_done pulses", pulses, 1);
      check("t4 log size", log_q.size(), 2);
      check_txn("t4 wb set1", 0, 1'b1, 16'h0110, BLK_D1, 1'b1);
      check_txn("t4 wb set5", 1, 1'b1, 16'h0050, BLK_D2, 1'b1);
      do_req(1'b0, 16'h0110, '0, 1'b0, rd, lat);
      check("t4 hit after flush latency", lat, 0);
      check("t4 hit after flush data", rd, BLK_D1);
      do_req(1'b0, 16'h0050, '0, 1'b0, rd, lat);
      check("t4 second hit data", rd, BLK_D2);
      check("t4 no pmem traffic after flush", log_q.size(), 2);

      // 5: reset during WRITEBACK drops pmem_write asynchronously
      do_req(1'b1, 16'h0060, BLK_W2, 1'b0, rd, lat);
      do_req(1'b0, 16'h00E0, '0, 1'b0, rd, lat);
      do_req(1'b0, 16'h0160, '0, 1'b0, rd, lat);
      do_req(1'b0, 16'h01E0, '0, 1'b0, rd, lat);
      log_q.delete();
      @(negedge clk);
      mem_address = 16'h0260;
      mem_read    = 1'b1;
      seen_wb     = 1'b0;
      for (int i = 0; i < 20 && !seen_wb; i++) begin
         @(negedge clk);
         seen_wb = pmem_write;
      end
      check("t5 writeback started", {127'd0, seen_wb}, {127'd0, 1'b1});
      check("t5 writeback address", {112'd0, pmem_address}, {112'd0, 16'h0060});
      #2;
      reset_n = 1'b0;
      #1;
      check("t5 pmem_write async low", {127'd0, pmem_write}, 128'd0);
      check("t5 pmem_address async zero", {112'd0, pmem_address}, 128'd0);
      mem_read = 1'b0;
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      do_req(1'b0, 16'h0060, '0, 1'b0, rd, lat);
      check("t5 miss after reset latency", lat, 4);
      check("t5 stale-free data", rd, PAT_060);
      check("t5 log size", log_q.size(), 1);
      check_txn("t5 refill", 0, 1'b0, 16'h0060, PAT_060, 1'b1);

      // 6: read and flush together; the read is serviced before the flush writeback
      do_req(1'b1, 16'h0060, BLK_W2, 1'b0, rd, lat);
      log_q.delete();
      do_req(1'b0, 16'h00E0, '0, 1'b1, rd, lat);
      check("t6 read serviced", lat, 4);
      wait_flush(pulses, done);
      check("t6 flush completes", {127'd0, done}, {127'd0, 1'b1});
      check("t6 flush_done pulses", pulses, 1);
      check("t6 log size", log_q.size(), 2);
      check_txn("t6 read first", 0, 1'b0, 16'h00E0, '0, 1'b0);
      check_txn("t6 flush wb second", 1, 1'b1, 16'h0060, BLK_W2, 1'b1);

      check("pmem read/write never overlap", {127'd0, both_seen}, 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/l2_cache_nway.md
Name: l2_cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L2 cache with integrated controller FSM.
- Sits between the L1/arbiter side (mem_*) and physical memory (pmem_*); moves whole lc3b_block (128-bit) lines.
- Generalises the 2-way L2 datapath:
  - arbitrary power-of-two ways and sets;
  - true LRU via per-way age counters;
  - properly sized tag;
  - registered victim;
  - whole-cache flush operation.

Parameters:
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 8, number of sets; power of two, 2..64.
- Derived, not overridable:
  - IDX_W = log2(SETS).
  - TAG_W = 12 - IDX_W.
  - AGE_W = log2(WAYS).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  upstream read request; held until mem_resp.
- mem_write  in  1  upstream write request; held until mem_resp.
- mem_address  in  16  byte address; bits [3:0] ignored.
- mem_wdata  in  128  write line.
- mem_rdata  out  128  read line; valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  16  line address, bits [3:0]=0.
- pmem_wdata  out  128  writeback line.
- pmem_rdata  in  128  fill data, valid with pmem_resp.
- pmem_resp  in  1  physical memory completion.
- flush_req  in  1  level request to write back all dirty lines.
- flush_done  out  1  one-cycle pulse when flush completes.

Behaviour:
- Address split: tag=addr[15:4+IDX_W], index=addr[3+IDX_W:4].
- Arrays: data, tag, valid, dirty per [set][way]; AGE_W-bit age per [set][way].
- Reset (async, reset_n=0):
  - state=CHECK; all valid=0, dirty=0; age[s][w]=w.
  - mem_resp, pmem_read, pmem_write, flush_done=0 immediately; pmem_address=0.
  - Data/tag arrays are not reset.
- FSM states: CHECK, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB.
- CHECK:
  - hit = OR over ways of (valid & tag match).
  - Read hit: mem_resp=1 combinationally in the same cycle; mem_rdata=hit way line.
  - Write hit: mem_resp=1; at the edge, data=mem_wdata and dirty=1.
  - Both mem_read and mem_write asserted: treated as a write.
  - Miss:
    - Register victim = lowest-index invalid way, else the way with age==WAYS-1.
    - Next state WRITEBACK if victim dirty, else FILL.
    - No mem_resp.
  - flush_req with no mem request pending: go to FLUSH_SCAN with scan pointer=0. A mem request takes priority in the same cycle.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 4'b0}, pmem_wdata=victim line.
  - On pmem_resp: victim dirty=0, go to FILL.
- FILL:
  - pmem_read=1, pmem_address={tag, index, 4'b0}.
  - On pmem_resp: data=pmem_rdata, tag written, valid=1, dirty=0; return to CHECK.
  - The request then hits the next cycle. Minimum miss latency is clean 2 cycles + pmem latency.
- LRU update on every hit (the cycle mem_resp=1) and every fill, for accessed way w:
  - every way v with age[v] < age[w] increments; age[w]=0.
  - Ages remain a permutation of 0..WAYS-1 at all times.
- Flush:
  - Scan pointer walks set-major (set ascending, way ascending), one entry per cycle in FLUSH_SCAN.
  - Valid & dirty entry: FLUSH_WB issues pmem_write of that line; on pmem_resp clears dirty and resumes the scan at the next entry.
  - After the last entry: flush_done=1 for one cycle, return to CHECK.
  - Valid bits and ages are unchanged by flush.
  - mem requests arriving during flush stall (no mem_resp) until CHECK.
- pmem_read and pmem_write are never asserted together. pmem outputs are stable while waiting for pmem_resp.
- The mem request must not change before mem_resp; behaviour is undefined otherwise.

Decomposition:
- lc3b_types supplies lc3b_block and lc3b_word.
- Add an l2_state_t enum (the five states above) to the package for bench visibility.
- Sub-module l2_lru_ages:
  - holds the per-set age arrays;
  - does the update on access;
  - outputs the victim way for an index;
  - takes valid bits for the invalid-first rule.

Test Plan:
1. After reset, read 0x1230 (index 3), pmem_resp with block A after 3 cycles → pmem_read with pmem_address=0x1230 and no pmem_write; then mem_resp=1 with mem_rdata=A.
2. Write hit 0x1230 with W → mem_resp on the first cycle; fill 0x1330, 0x1430, 0x1530; read 0x1630 → pmem_write at 0x1230 with data W, then pmem_read at 0x1630.
3. Fill the four lines of test 2 clean, read 0x1230 again, then read 0x1630 → evicted way is 0x1330's line (no pmem_write, pmem_read 0x1630); 0x1230 still hits.
4. Dirty lines in set 1 way 2 and set 5 way 0, assert flush_req → pmem_write at set 1 then set 5; flush_done pulses exactly once; a subsequent read of either line hits with no pmem traffic.
5. Assert reset_n=0 mid-WRITEBACK → pmem_write falls without a clock; after release, a read of a previously cached address misses with pmem_read.
6. mem_read and flush_req asserted in the same cycle in CHECK → the read is serviced first; the flush starts after mem_resp.
